// File: rtl/controlador_exibicao_sequencia.sv
// Plays back the stored memory-game sequence on the LEDs for one round:
// each RAM value from address 0 to the latched limit is lit, then blanked.
module controlador_exibicao_sequencia #(
    parameter int T_ACESO   = 500,
    parameter int T_APAGADO = 250,
    parameter int TIMER_W   = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       abortar,
    input  logic [3:0] limite,
    input  logic [3:0] dado_memoria,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       exibindo,
    output logic       pronto,
    output logic [4:0] db_estado
);

    typedef enum logic [4:0] {
        INICIAL        = 5'b00000,
        PREPARA        = 5'b00001,
        MOSTRA_LED     = 5'b00011,
        MOSTRA_APAGADO = 5'b00101,
        PROXIMO        = 5'b00110,
        FINAL          = 5'b01111
    } estado_t;

    localparam logic [TIMER_W-1:0] ULT_ACESO   = TIMER_W'(T_ACESO - 1);
    localparam logic [TIMER_W-1:0] ULT_APAGADO = TIMER_W'(T_APAGADO - 1);
    localparam logic [TIMER_W-1:0] TIMER_ZERO  = {TIMER_W{1'b0}};
    localparam logic [TIMER_W-1:0] TIMER_UM    = {{(TIMER_W-1){1'b0}}, 1'b1};

    estado_t            estado_r, estado_s;
    logic [TIMER_W-1:0] timer_r, timer_s;
    logic [3:0]         endereco_r, endereco_s;
    logic [3:0]         limite_r, limite_s;

    // State, timer, address and latched limit registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_r   <= INICIAL;
            timer_r    <= TIMER_ZERO;
            endereco_r <= 4'd0;
            limite_r   <= 4'd0;
        end else begin
            estado_r   <= estado_s;
            timer_r    <= timer_s;
            endereco_r <= endereco_s;
            limite_r   <= limite_s;
        end
    end

    // Next-state logic; abort beats every transition, including FINAL
    always_comb begin
        estado_s   = estado_r;
        timer_s    = timer_r;
        endereco_s = endereco_r;
        limite_s   = limite_r;
        if (abortar && (estado_r != INICIAL)) begin
            estado_s = INICIAL;
            timer_s  = TIMER_ZERO;
        end else begin
            case (estado_r)
                INICIAL: begin
                    if (iniciar && !abortar) begin
                        estado_s = PREPARA;
                    end else begin
                        estado_s = INICIAL;
                    end
                end
                PREPARA: begin
                    endereco_s = 4'd0;
                    timer_s    = TIMER_ZERO;
                    limite_s   = limite;
                    estado_s   = MOSTRA_LED;
                end
                MOSTRA_LED: begin
                    if (timer_r == ULT_ACESO) begin
                        timer_s  = TIMER_ZERO;
                        estado_s = MOSTRA_APAGADO;
                    end else begin
                        timer_s  = timer_r + TIMER_UM;
                    end
                end
                MOSTRA_APAGADO: begin
                    if (timer_r == ULT_APAGADO) begin
                        timer_s = TIMER_ZERO;
                        if (endereco_r == limite_r) begin
                            estado_s = FINAL;
                        end else begin
                            estado_s = PROXIMO;
                        end
                    end else begin
                        timer_s = timer_r + TIMER_UM;
                    end
                end
                PROXIMO: begin
                    endereco_s = endereco_r + 4'd1;
                    estado_s   = MOSTRA_LED;
                end
                FINAL: begin
                    estado_s = INICIAL;
                end
                default: begin
                    estado_s = INICIAL;
                    timer_s  = TIMER_ZERO;
                end
            endcase
        end
    end

    // Moore output decode; LEDs pass RAM data straight through while lit
    always_comb begin
        leds     = 4'd0;
        exibindo = 1'b0;
        pronto   = 1'b0;
        case (estado_r)
            PREPARA:        exibindo = 1'b1;
            MOSTRA_LED: begin
                exibindo = 1'b1;
                leds     = dado_memoria;
            end
            MOSTRA_APAGADO: exibindo = 1'b1;
            PROXIMO:        exibindo = 1'b1;
            FINAL:          pronto   = 1'b1;
            default: begin
                leds     = 4'd0;
                exibindo = 1'b0;
                pronto   = 1'b0;
            end
        endcase
    end

    assign endereco  = endereco_r;
    assign db_estado = estado_r;

endmodule

// File: tb/tb_controlador_exibicao_sequencia.sv
// Directed bench for controlador_exibicao_sequencia: a short-timer instance
// driven from vector tables/sequences, plus a default-timer instance.
module tb_controlador_exibicao_sequencia;

    localparam logic [4:0] S_INI = 5'b00000;
    localparam logic [4:0] S_PRE = 5'b00001;
    localparam logic [4:0] S_LED = 5'b00011;
    localparam logic [4:0] S_APA = 5'b00101;
    localparam logic [4:0] S_PRX = 5'b00110;
    localparam logic [4:0] S_FIN = 5'b01111;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0, abortar = 1'b0;
    logic [3:0] limite = 4'd0;
    logic [3:0] dado_memoria, endereco, leds;
    logic       exibindo, pronto;
    logic [4:0] db_estado;
    logic [3:0] ram [16];

    logic       iniciar2 = 1'b0;
    logic [3:0] endereco2, leds2;
    logic       exibindo2, pronto2;
    logic [4:0] db_estado2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;
    assign dado_memoria = ram[endereco];

    controlador_exibicao_sequencia #(.T_ACESO(4), .T_APAGADO(2), .TIMER_W(10)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .abortar(abortar),
        .limite(limite), .dado_memoria(dado_memoria), .endereco(endereco),
        .leds(leds), .exibindo(exibindo), .pronto(pronto), .db_estado(db_estado)
    );

    controlador_exibicao_sequencia dut2 (
        .clock(clock), .reset(reset), .iniciar(iniciar2), .abortar(1'b0),
        .limite(4'd0), .dado_memoria(4'b1001), .endereco(endereco2),
        .leds(leds2), .exibindo(exibindo2), .pronto(pronto2), .db_estado(db_estado2)
    );

    typedef struct {
        logic       ini;
        logic       abo;
        logic [3:0] lim;
        logic [3:0] e_leds;
        logic       e_exib;
        logic       e_pronto;
        logic [3:0] e_end;
        logic [4:0] e_est;
    } vec_t;

    vec_t tab [11];

    function automatic vec_t mk(logic ini, logic abo, logic [3:0] lim, logic [3:0] el,
                                logic ee, logic ep, logic [3:0] en, logic [4:0] es);
        vec_t v;
        v.ini = ini; v.abo = abo; v.lim = lim; v.e_leds = el;
        v.e_exib = ee; v.e_pronto = ep; v.e_end = en; v.e_est = es;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [3:0] el, input logic ee, input logic ep,
                       input logic ce, input logic [3:0] en, input logic [4:0] es);
        n_vec++;
        if (leds !== el || exibindo !== ee || pronto !== ep || db_estado !== es ||
            (ce && endereco !== en)) begin
            n_err++;
            $display("FAIL %s t=%0t: got leds=%b exib=%b pronto=%b end=%0d est=%b, exp leds=%b exib=%b pronto=%b end=%0d(chk=%b) est=%b",
                     nm, $time, leds, exibindo, pronto, endereco, db_estado, el, ee, ep, en, ce, es);
        end
    endtask

    task automatic vec(input string nm, input logic ini, input logic abo, input logic [3:0] lim,
                       input logic [3:0] el, input logic ee, input logic ep,
                       input logic ce, input logic [3:0] en, input logic [4:0] es);
        @(negedge clock);
        iniciar = ini; abortar = abo; limite = lim;
        #1;
        chk(nm, el, ee, ep, ce, en, es);
    endtask

    task automatic cmp_int(input string nm, input int got, input int exp_v);
        n_vec++;
        if (got != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, exp %0d", nm, got, exp_v);
        end
    endtask

    // Full playback of limite+1 values; with noise, iniciar toggles and limite
    // jumps to 5 after the latch point, neither of which may have any effect.
    task automatic play(input string nm, input logic [3:0] lim, input logic noise);
        logic [3:0] lim_d;
        lim_d = noise ? 4'd5 : lim;
        vec({nm, "_ini"}, 1'b1, 1'b0, lim, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, S_INI);
        vec({nm, "_pre"}, 1'b0, 1'b0, lim, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, S_PRE);
        for (int i = 0; i <= int'(lim); i++) begin
            for (int c = 0; c < 4; c++)
                vec({nm, "_led"}, noise & c[0], 1'b0, lim_d, ram[i], 1'b1, 1'b0, 1'b1, 4'(i), S_LED);
            for (int c = 0; c < 2; c++)
                vec({nm, "_apa"}, noise, 1'b0, lim_d, 4'd0, 1'b1, 1'b0, 1'b1, 4'(i), S_APA);
            if (i < int'(lim))
                vec({nm, "_prx"}, noise, 1'b0, lim_d, 4'd0, 1'b1, 1'b0, 1'b1, 4'(i), S_PRX);
        end
        vec({nm, "_fin"}, 1'b0, 1'b0, lim_d, 4'd0, 1'b0, 1'b1, 1'b1, lim, S_FIN);
        vec({nm, "_idle"}, 1'b0, 1'b0, lim_d, 4'd0, 1'b0, 1'b0, 1'b1, lim, S_INI);
    endtask

    initial begin
        int lit, first_lit, pcnt, pcyc, ecnt;
        for (int i = 0; i < 16; i++) ram[i] = 4'd0;
        ram[0] = 4'b0001;

        #1;
        chk("reset", 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, S_INI);
        @(negedge clock);
        reset = 1'b0;

        // Single value, limite=0: pronto 8 cycles after the iniciar edge
        tab[0]  = mk(1'b1, 1'b0, 4'd0, 4'd0,    1'b0, 1'b0, 4'd0, S_INI);
        tab[1]  = mk(1'b0, 1'b0, 4'd0, 4'd0,    1'b1, 1'b0, 4'd0, S_PRE);
        tab[2]  = mk(1'b0, 1'b0, 4'd0, 4'b0001, 1'b1, 1'b0, 4'd0, S_LED);
        tab[3]  = mk(1'b0, 1'b0, 4'd0, 4'b0001, 1'b1, 1'b0, 4'd0, S_LED);
        tab[4]  = mk(1'b0, 1'b0, 4'd0, 4'b0001, 1'b1, 1'b0, 4'd0, S_LED);
        tab[5]  = mk(1'b0, 1'b0, 4'd0, 4'b0001, 1'b1, 1'b0, 4'd0, S_LED);
        tab[6]  = mk(1'b0, 1'b0, 4'd0, 4'd0,    1'b1, 1'b0, 4'd0, S_APA);
        tab[7]  = mk(1'b0, 1'b0, 4'd0, 4'd0,    1'b1, 1'b0, 4'd0, S_APA);
        tab[8]  = mk(1'b0, 1'b0, 4'd0, 4'd0,    1'b0, 1'b1, 4'd0, S_FIN);
        tab[9]  = mk(1'b0, 1'b0, 4'd0, 4'd0,    1'b0, 1'b0, 4'd0, S_INI);
        tab[10] = mk(1'b0, 1'b0, 4'd0, 4'd0,    1'b0, 1'b0, 4'd0, S_INI);
        for (int i = 0; i < 11; i++)
            vec("tab1", tab[i].ini, tab[i].abo, tab[i].lim, tab[i].e_leds, tab[i].e_exib,
                tab[i].e_pronto, 1'b1, tab[i].e_end, tab[i].e_est);

        ram[0] = 4'b0001; ram[1] = 4'b0010; ram[2] = 4'b0100; ram[3] = 4'b1000;
        play("lim3", 4'd3, 1'b0);

        for (int i = 0; i < 16; i++) ram[i] = i[0] ? 4'b1010 : 4'b0101;
        play("lim15", 4'd15, 1'b0);

        ram[0] = 4'b0001; ram[1] = 4'b0010; ram[2] = 4'b0100; ram[3] = 4'b1000;
        play("noise", 4'd2, 1'b1);

        // Abort: ignored-iniciar in INICIAL, then abort during the 2nd value
        vec("abo_ini", 1'b1, 1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, S_INI);
        vec("abo_ini2", 1'b0, 1'b0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, S_INI);
        vec("abo_go", 1'b1, 1'b0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, S_INI);
        vec("abo_pre", 1'b0, 1'b0, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, S_PRE);
        for (int c = 0; c < 4; c++)
            vec("abo_led0", 1'b0, 1'b0, 4'd3, 4'b0001, 1'b1, 1'b0, 1'b1, 4'd0, S_LED);
        for (int c = 0; c < 2; c++)
            vec("abo_apa0", 1'b0, 1'b0, 4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, S_APA);
        vec("abo_prx", 1'b0, 1'b0, 4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, S_PRX);
        vec("abo_led1", 1'b0, 1'b0, 4'd3, 4'b0010, 1'b1, 1'b0, 1'b1, 4'd1, S_LED);
        vec("abo_hit", 1'b0, 1'b1, 4'd3, 4'b0010, 1'b1, 1'b0, 1'b1, 4'd1, S_LED);
        for (int c = 0; c < 12; c++)
            vec("abo_after", 1'b0, 1'b0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, S_INI);
        play("restart", 4'd3, 1'b0);

        // Async reset between edges during MOSTRA_APAGADO
        vec("rst_go", 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, S_INI);
        vec("rst_pre", 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, S_PRE);
        for (int c = 0; c < 4; c++)
            vec("rst_led", 1'b0, 1'b0, 4'd0, 4'b0001, 1'b1, 1'b0, 1'b1, 4'd0, S_LED);
        vec("rst_apa", 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, S_APA);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async", 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, S_INI);
        @(negedge clock);
        reset = 1'b0;
        play("post_rst", 4'd0, 1'b0);

        // Default timers: 500 lit cycles, pronto at edge+752
        @(negedge clock);
        iniciar2 = 1'b1;
        @(negedge clock);
        iniciar2 = 1'b0;
        lit = 0; first_lit = 0; pcnt = 0; pcyc = 0; ecnt = 0;
        for (int c = 1; c <= 760; c++) begin
            if (leds2 == 4'b1001) begin
                if (lit == 0) first_lit = c;
                lit++;
            end
            if (pronto2) begin
                pcnt++;
                pcyc = c;
                cmp_int("dflt_fin_state", int'(db_estado2), int'(S_FIN));
            end
            if (exibindo2) ecnt++;
            @(negedge clock);
        end
        cmp_int("dflt_lit_cycles", lit, 500);
        cmp_int("dflt_first_lit", first_lit, 2);
        cmp_int("dflt_pronto_cycle", pcyc, 752);
        cmp_int("dflt_pronto_count", pcnt, 1);
        cmp_int("dflt_exibindo_cycles", ecnt, 751);
        cmp_int("dflt_endereco", int'(endereco2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
